sync_ram_arbiter: RTL and testbench
===================================

SYNC_RAM_ARBITER -- requirements
Module: sync_ram_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_W, 4, RAM address width; DATA_W, 8, RAM data width.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) command valid.
REQ-005 reqN_ready  output  1  command accepted this cycle (combinational grant).
REQ-006 reqN_we  input  1  1 = write, 0 = read.
REQ-007 reqN_addr  input  ADDR_W  target address.
REQ-008 reqN_wdata  input  DATA_W  write data.
REQ-009 rspN_valid  output  1  read data for requester N valid, one-cycle pulse.
REQ-010 rspN_rdata  output  DATA_W  read data, meaningful only with rspN_valid.
REQ-011 ram_we, ram_addr, ram_din  output  1/ADDR_W/DATA_W  registered RAM command, connects to sync_ram we/addr/din.
REQ-012 ram_dout  input  DATA_W  RAM registered read data.
REQ-013 gntN_cnt  output  8  accepted-command count for requester N.

Function
- Arbitration
REQ-014 A command SHALL be accepted in a cycle exactly when reqN_valid and reqN_ready are both 1; at most one ready SHALL be 1 per cycle.
REQ-015 With one requester valid, that requester SHALL be granted regardless of priority.
REQ-016 With both valid, the requester indicated by the 1-bit priority pointer SHALL be granted.
REQ-017 After each accepted command, the pointer SHALL point to the non-granted requester; with no grant it SHALL hold.
REQ-018 reqN_ready SHALL NOT depend on reqN_we, addr or wdata; no back-pressure from responses.
- RAM command stage
REQ-019 At the edge ending an accept cycle N, ram_addr/ram_din SHALL load the granted fields and ram_we SHALL load the granted we; in cycle N+1 the RAM sees the command.
REQ-020 With no accept, ram_we SHALL be 0 next cycle; ram_addr and ram_din SHALL hold.
REQ-021 Throughput SHALL be one command per cycle, back-to-back, any requester mix.
- Response pipeline
REQ-022 A 2-stage tag pipeline (valid, is_read, id) SHALL track each accepted command.
REQ-023 A read accepted in cycle N SHALL produce rspN_valid=1 for the issuing requester only, in cycle N+2, with rspN_rdata = ram_dout.
REQ-024 Writes SHALL produce no response.
REQ-025 A write accepted in cycle N followed by a read of the same address accepted in cycle N+1 SHALL return the newly written data.
REQ-026 rspN_rdata SHALL equal ram_dout continuously; only rspN_valid qualifies it.
- Counters
REQ-027 gntN_cnt SHALL increment by 1 on every accept of requester N, wrapping 255 -> 0.

Reset
REQ-028 On rst_n low, asynchronously: pointer=0, ram_we=0, ram_addr=0, ram_din=0, tag pipeline cleared, rsp0_valid=rsp1_valid=0, gnt0_cnt=gnt1_cnt=0.
REQ-029 Reset mid-operation SHALL discard in-flight reads; no rspN_valid pulse SHALL appear for commands accepted before reset.
REQ-030 reqN_ready SHALL be 0 while rst_n is low.
REQ-031 RAM contents SHALL NOT be cleared by this block.

Structure
REQ-032 ADDR_W/DATA_W defaults and the tag record (valid, is_read, id) SHALL live in a shared package sync_ram_pkg.
REQ-033 The 2-input round-robin grant logic with pointer SHALL be one sub-module, rr_arb2; the rest is flat.
REQ-034 The bench SHALL instantiate sync_ram_arbiter connected to sync_ram (16x8).

Verification
REQ-035 Req0 writes 0xA5 to addr 4, then reads addr 4 -> rsp0_valid 2 cycles after read accept, rdata 0xA5; rsp1_valid stays 0.
REQ-036 Both valid every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; gnt0_cnt=gnt1_cnt=3.
REQ-037 Req1 writes 0x3C to addr 8 in cycle N, req0 reads addr 8 in N+1 -> rsp0_rdata 0x3C in N+3.
REQ-038 Only req1 valid for 4 cycles reading addrs 0..3 (preloaded 0x10..0x13) -> 4 consecutive rsp1 pulses 0x10..0x13, pointer=0 afterwards.
REQ-039 Read accepted, rst_n pulled low next cycle -> no rspN_valid pulse, all outputs at reset values.
REQ-040 256 accepts from req0 -> gnt0_cnt wraps to 0.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// Shared widths and the response-tracking tag carried alongside each accepted command.
package sync_ram_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef struct packed {
        logic valid;
        logic is_read;
        logic id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, is_read: 1'b0, id: 1'b0};
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser after each grant.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    output logic gnt0,
    output logic gnt1
);
    logic ptr;

    // Grants are gated by reset so no command is taken while the block is held in reset.
    assign gnt0 = rst_n & valid0 & (~valid1 | ~ptr);
    assign gnt1 = rst_n & valid1 & (~valid0 |  ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end
endmodule

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with registered read data; contents have no reset.
module sync_ram #(
    parameter int ADDR_W = sync_ram_pkg::ADDR_W_DEF,
    parameter int DATA_W = sync_ram_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end
endmodule

// File: rtl/sync_ram_arbiter.sv
// Two-requester front end for a synchronous RAM: round-robin grant, registered RAM
// command, and a two-stage tag pipeline that routes read data back to its issuer.
module sync_ram_arbiter #(
    parameter int ADDR_W = sync_ram_pkg::ADDR_W_DEF,
    parameter int DATA_W = sync_ram_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [7:0]        gnt0_cnt,
    output logic [7:0]        gnt1_cnt
);
    import sync_ram_pkg::*;

    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    tag_t              tag_s1;
    tag_t              tag_s2;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;
    assign sel_we     = gnt1 ? req1_we    : req0_we;
    assign sel_addr   = gnt1 ? req1_addr  : req0_addr;
    assign sel_wdata  = gnt1 ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            tag_s1   <= TAG_IDLE;
            tag_s2   <= TAG_IDLE;
            gnt0_cnt <= 8'd0;
            gnt1_cnt <= 8'd0;
        end else begin
            ram_we <= accept & sel_we;
            if (accept) begin
                ram_addr <= sel_addr;
                ram_din  <= sel_wdata;
            end
            // Stage 1 lines up with the RAM command, stage 2 with the RAM's registered dout.
            tag_s1 <= '{valid: accept, is_read: ~sel_we, id: gnt1};
            tag_s2 <= tag_s1;
            if (gnt0) gnt0_cnt <= gnt0_cnt + 8'd1;
            if (gnt1) gnt1_cnt <= gnt1_cnt + 8'd1;
        end
    end

    assign rsp0_valid = tag_s2.valid & tag_s2.is_read & ~tag_s2.id;
    assign rsp1_valid = tag_s2.valid & tag_s2.is_read &  tag_s2.id;
    assign rsp0_rdata = ram_dout;
    assign rsp1_rdata = ram_dout;
endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Scoreboard bench: arbiter + 16x8 RAM against a behavioural model of grants, memory and responses.
module tb_sync_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req0_addr, req1_addr, ram_addr;
    logic [DW-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, ram_din, ram_dout;
    logic          rsp0_valid, rsp1_valid, ram_we;
    logic [7:0]    gnt0_cnt, gnt1_cnt;

    always #5 clk = ~clk;

    sync_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
    );

    sync_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
        .clk(clk), .we(ram_we), .addr(ram_addr), .din(ram_din), .dout(ram_dout)
    );

    typedef struct {
        int           due;
        bit           id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] mem_m [16];
    bit            ptr_m;
    logic [7:0]    cnt_m0, cnt_m1;
    bit            pwe;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdin;
    bit            hit, e0, e1;
    exp_t          cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: at most one response per cycle, so a single time-ordered queue suffices.
    always @(negedge clk) begin
        hit = (q.size() > 0) && (q[0].due == cyc);
        e0 = 1'b0;
        e1 = 1'b0;
        if (hit) begin
            cur = q.pop_front();
            e0 = !cur.id;
            e1 = cur.id;
        end
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e1));
        if (e0) chk("rsp0_rdata", 32'(rsp0_rdata), 32'(cur.data));
        if (e1) chk("rsp1_rdata", 32'(rsp1_rdata), 32'(cur.data));
    end

    task automatic step(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit g0, g1, id, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        @(negedge clk);
        chk("ram_we", 32'(ram_we), 32'(pwe));
        chk("ram_addr", 32'(ram_addr), 32'(paddr));
        chk("ram_din", 32'(ram_din), 32'(pdin));
        chk("gnt0_cnt", 32'(gnt0_cnt), 32'(cnt_m0));
        chk("gnt1_cnt", 32'(gnt1_cnt), 32'(cnt_m1));
        g0 = v0 && (!v1 || !ptr_m);
        g1 = v1 && (!v0 || ptr_m);
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        if (g0 || g1) begin
            id = g1;
            we = g1 ? we1 : we0;
            a  = g1 ? a1 : a0;
            d  = g1 ? d1 : d0;
            if (we) mem_m[a] = d;
            else    q.push_back('{due: cyc + 2, id: id, data: mem_m[a]});
            pwe = we; paddr = a; pdin = d;
            if (id) cnt_m1++; else cnt_m0++;
            ptr_m = !id;
        end else begin
            pwe = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_gnt0_cnt", 32'(gnt0_cnt), 32'd0);
        chk("rst_gnt1_cnt", 32'(gnt1_cnt), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        q.delete();
        ptr_m = 1'b0; cnt_m0 = 8'd0; cnt_m1 = 8'd0;
        pwe = 1'b0; paddr = '0; pdin = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        for (int i = 0; i < 16; i++) mem_m[i] = 'x;
        do_reset();

        // Both requesters valid every cycle: grants must alternate starting with 0.
        for (int i = 0; i < 6; i++) step(1, 1, AW'(i), DW'(8'h50 + i), 1, 1, AW'(i + 8), DW'(8'h60 + i));
        idle(1);
        chk("alt_gnt0_cnt", 32'(gnt0_cnt), 32'd3);
        chk("alt_gnt1_cnt", 32'(gnt1_cnt), 32'd3);

        // Known contents everywhere; addresses 0..3 hold 0x10..0x13.
        for (int i = 0; i < 16; i++)
            step(1, 1, AW'(i), (i < 4) ? DW'(8'h10 + i) : DW'($urandom), 0, 0, '0, '0);

        // Write then read back through requester 0.
        step(1, 1, 4'd4, 8'hA5, 0, 0, '0, '0);
        step(1, 0, 4'd4, 8'h00, 0, 0, '0, '0);
        idle(3);

        // Requester 1 writes, requester 0 reads the same address in the very next cycle.
        step(0, 0, '0, '0, 1, 1, 4'd8, 8'h3C);
        step(1, 0, 4'd8, 8'h00, 0, 0, '0, '0);
        idle(3);

        // Requester 1 alone, four back-to-back reads; then a contested cycle must go to 0.
        for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1, 0, AW'(i), '0);
        step(1, 0, 4'd2, '0, 1, 0, 4'd3, '0);
        idle(4);

        // Reset right after a read is accepted: its response must never appear.
        step(1, 0, 4'd5, '0, 0, 0, '0, '0);
        do_reset();
        idle(4);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)), DW'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)), DW'($urandom));
        idle(4);

        do_reset();
        for (int i = 0; i < 256; i++) step(1, 1, AW'($urandom_range(0, 15)), DW'($urandom), 0, 0, '0, '0);
        idle(1);
        chk("wrap_gnt0_cnt", 32'(gnt0_cnt), 32'd0);
        idle(3);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
